// File: rtl/mem_axi_bridge.sv
// Single-outstanding bridge from the core's SRAM-style memory request to AXI3 single-beat reads/writes.
// Build option BRIDGE_FASTRESP_EN: no DONE state; completion is signalled on the R/B handshake cycle.
module mem_axi_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] mem_a,
  input  logic              mem_access,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_st_data,
  input  logic              flush,
  output logic              mem_ready,
  output logic [31:0]       mem_data,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [3:0]        strb_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              flushed;
  logic              mem_ready_q;
  logic              r_hs;
  logic              b_hs;
  logic              kill;
  logic              aw_left;
  logic              w_left;

  assign r_hs    = (state == RDATA) & rvalid & rready;
  assign b_hs    = (state == WRESP) & bvalid & bready;
  // A flush arriving on the completion cycle must suppress the result just like an earlier one.
  assign kill    = flushed | flush;
  assign aw_left = awvalid & ~awready;
  assign w_left  = wvalid & ~wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      mem_ready_q <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      strb_q      <= '0;
      wdata_q     <= '0;
      flushed     <= 1'b0;
    end else begin
      mem_ready_q <= 1'b0;
      if (state != IDLE && flush) flushed <= 1'b1;
      case (state)
        IDLE: begin
          flushed <= 1'b0;
          if (mem_access && !flush) begin
            addr_q  <= mem_a;
            size_q  <= mem_size;
            strb_q  <= mem_sel;
            wdata_q <= mem_st_data;
            if (mem_write) begin
              state   <= WREQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (r_hs) begin
            rready <= 1'b0;
            if (!kill) data_q <= rdata;
`ifdef BRIDGE_FASTRESP_EN
            state   <= IDLE;
            flushed <= 1'b0;
`else
            mem_ready_q <= ~kill;
            state       <= DONE;
`endif
          end
        end
        WREQ: begin
          // AW and W retire independently; the response phase waits for both.
          awvalid <= aw_left;
          wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (b_hs) begin
            bready <= 1'b0;
`ifdef BRIDGE_FASTRESP_EN
            state   <= IDLE;
            flushed <= 1'b0;
`else
            mem_ready_q <= ~kill;
            state       <= DONE;
`endif
          end
        end
        DONE: begin
          flushed <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = wdata_q;
  assign wstrb  = strb_q;

`ifdef BRIDGE_FASTRESP_EN
  assign mem_ready = mem_ready_q | ((r_hs | b_hs) & ~kill);
  assign mem_data  = (r_hs & ~kill) ? rdata : data_q;
`else
  assign mem_ready = mem_ready_q;
  assign mem_data  = data_q;
`endif

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Directed plus randomized bench for mem_axi_bridge (default build, registered DONE completion).
module tb_mem_axi_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] mem_a;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        flush;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_data;

  mem_axi_bridge #(.ADDR_W(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write),
    .mem_size(mem_size), .mem_sel(mem_sel), .mem_st_data(mem_st_data),
    .flush(flush), .mem_ready(mem_ready), .mem_data(mem_data),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request with a slave that waits d0 (AR/AW), d1 (R/W) and d2 (B) cycles before answering.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] sel, input logic [31:0] sd, input logic [31:0] rd,
                         input int d0, input int d1, input int d2, input int flush_at);
    int cyc, ready_cyc, pulses, aw_hi, w_hi, bad, idle_left, c0, c1, c2, exp_lat;
    bit resp_done, killed;
    cyc = 0; ready_cyc = -1; pulses = 0; aw_hi = 0; w_hi = 0; bad = 0;
    idle_left = 3; c0 = 0; c1 = 0; c2 = 0; resp_done = 0;
    killed = (flush_at >= 0);
    @(negedge aclk);
    mem_a = a; mem_write = wr; mem_size = sz; mem_sel = sel; mem_st_data = sd;
    mem_access = 1'b1;
    while (idle_left > 0 && cyc < 200) begin
      @(negedge aclk);
      cyc++;
      flush = 1'b0;
      // Anything driven last cycle met a stable valid/ready and completed at the edge just passed.
      arready = 1'b0; awready = 1'b0; wready = 1'b0;
      if (rvalid || bvalid) resp_done = 1'b1;
      rvalid = 1'b0; bvalid = 1'b0;
      if (mem_ready) begin
        pulses++;
        if (ready_cyc < 0) ready_cyc = cyc;
        mem_access = 1'b0;
      end
      if (wr ? arvalid : (awvalid | wvalid)) bad++;
      if (bready && (awvalid || wvalid)) bad++;
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (cyc == flush_at) begin
        flush = 1'b1;
        mem_access = 1'b0;
      end
      if (!wr) begin
        if (arvalid) begin
          if (c0 >= d0) begin
            check("araddr", 64'(araddr), 64'(a));
            check("arsize", 64'(arsize), 64'({1'b0, sz}));
            arready = 1'b1;
          end else c0++;
        end
        if (rready && !resp_done) begin
          if (c1 >= d1) begin
            rvalid = 1'b1;
            rdata  = rd;
          end else c1++;
        end
      end else begin
        if (awvalid) begin
          if (c0 >= d0) begin
            check("awaddr", 64'(awaddr), 64'(a));
            check("awsize", 64'(awsize), 64'({1'b0, sz}));
            awready = 1'b1;
          end else c0++;
        end
        if (wvalid) begin
          if (c1 >= d1) begin
            check("wdata", 64'(wdata), 64'(sd));
            check("wstrb", 64'(wstrb), 64'(sel));
            wready = 1'b1;
          end else c1++;
        end
        if (bready && !resp_done) begin
          if (c2 >= d2) bvalid = 1'b1;
          else c2++;
        end
      end
      if (resp_done) idle_left--;
    end
    flush = 1'b0;
    mem_access = 1'b0;
    check("txn_done", 64'(resp_done), 64'(1));
    // Accept, address phase (+waits), data/response phase (+waits), then the completion cycle.
    exp_lat = wr ? 3 + ((d0 > d1) ? d0 : d1) + d2 : 3 + d0 + d1;
    if (!killed && !wr) model_data = rd;
    check("ready_pulses", 64'(pulses), killed ? 64'(0) : 64'(1));
    if (!killed) check("latency", 64'(ready_cyc), 64'(exp_lat));
    check("mem_data", 64'(mem_data), 64'(model_data));
    check("protocol", 64'(bad), 64'(0));
    if (wr) begin
      check("aw_cycles", 64'(aw_hi), 64'(d0 + 1));
      check("w_cycles", 64'(w_hi), 64'(d1 + 1));
    end
    check("idle_ctrl", 64'({arvalid, awvalid, wvalid, rready, bready, mem_ready}), 64'(0));
  endtask

  initial begin
    int fa;
    aresetn = 1'b0; mem_a = '0; mem_access = 1'b0; mem_write = 1'b0; mem_size = '0;
    mem_sel = '0; mem_st_data = '0; flush = 1'b0; arready = 1'b0; rdata = '0;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    model_data = '0;
    repeat (2) @(negedge aclk);
    check("rst_ctrl", 64'({mem_ready, arvalid, rready, awvalid, wvalid, bready}), 64'(0));
    check("rst_mem_data", 64'(mem_data), 64'(0));
    check("rst_addr", {araddr, awaddr}, 64'(0));
    aresetn = 1'b1;

    run_txn(1'b0, 32'hBFC0_0000, 2'b10, 4'h0, 32'h0, 32'h3C1D_0001, 0, 2, 0, -1);
    run_txn(1'b1, 32'h1FAF_0004, 2'b00, 4'b0010, 32'h0000_AB00, 32'h0, 3, 0, 0, -1);
    run_txn(1'b0, 32'h0040_0010, 2'b10, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 3);
    run_txn(1'b0, 32'h0040_0014, 2'b01, 4'h0, 32'h0, 32'h1234_5678, 1, 0, 0, -1);
    run_txn(1'b1, 32'h8000_0100, 2'b10, 4'b1111, 32'hCAFE_F00D, 32'h0, 2, 2, 1, -1);
    run_txn(1'b1, 32'h8000_0104, 2'b01, 4'b1100, 32'h5555_0000, 32'h0, 0, 3, 2, 1);

    // A request that arrives together with flush in IDLE must never start.
    @(negedge aclk);
    mem_access = 1'b1; mem_write = 1'b1; flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("idle_flush_valids", 64'({arvalid, awvalid, wvalid}), 64'(0));
    end
    mem_access = 1'b0; flush = 1'b0;
    @(negedge aclk);
    check("idle_flush_after", 64'({arvalid, awvalid, wvalid, mem_ready}), 64'(0));

    for (int n = 0; n < 24; n++) begin
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : -1;
      run_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)),
              4'($urandom_range(0, 15)), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)), fa);
    end

    // Asynchronous reset with a write stalled in its address/data phase.
    @(negedge aclk);
    mem_a = 32'h0000_0040; mem_write = 1'b1; mem_size = 2'b10; mem_sel = 4'hF;
    mem_st_data = 32'hA5A5_5A5A; mem_access = 1'b1;
    @(negedge aclk);
    mem_access = 1'b0;
    check("pre_rst_valids", 64'({awvalid, wvalid}), 64'(2'b11));
    #2 aresetn = 1'b0;
    #1;
    check("arst_ctrl", 64'({mem_ready, arvalid, rready, awvalid, wvalid, bready}), 64'(0));
    check("arst_mem_data", 64'(mem_data), 64'(0));
    check("arst_addr", {araddr, awaddr}, 64'(0));
    check("arst_payload", 64'({wdata, wstrb, arsize, awsize}), 64'(0));
    model_data = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    run_txn(1'b0, 32'h0000_0080, 2'b10, 4'h0, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
